// File: rtl/systolic_pkg.sv
// Shared types and default widths for the systolic array sequencer.
package systolic_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned N_DEF = 4;

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} ctrl_state_t;

  typedef logic [DW-1:0] elem_t;

endpackage

// File: rtl/systolic_skew_gen.sv
// Operand buffers plus skewed wavefront slices: lane i emits A[i][t-i] and B[t-i][i] or zero.
module systolic_skew_gen #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 3
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_k,
  input  logic [N*DW-1:0] ld_a,
  input  logic [N*DW-1:0] ld_b,
  input  logic [CW-1:0]   t,
  output logic [N*DW-1:0] a_skew,
  output logic [N*DW-1:0] b_skew
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  for (genvar i = 0; i < N; i++) begin : g_lane
    // a_row holds row i of A, b_col holds column i of B, both indexed by k.
    logic [DW-1:0] a_row [N];
    logic [DW-1:0] b_col [N];
    logic [CW-1:0] d;
    logic          hit;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        a_row[wr_k[KW-1:0]] <= ld_a[i*DW +: DW];
        b_col[wr_k[KW-1:0]] <= ld_b[i*DW +: DW];
      end
    end

    assign d   = t - CW'(i);
    assign hit = (t >= CW'(i)) && (d < CW'(N));

    assign a_skew[i*DW +: DW] = hit ? a_row[d[KW-1:0]] : '0;
    assign b_skew[i*DW +: DW] = hit ? b_col[d[KW-1:0]] : '0;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: load, skewed feed, drain, done.
module systolic_ctrl #(
  parameter int unsigned N  = systolic_pkg::N_DEF,
  parameter int unsigned DW = systolic_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [N*DW-1:0] ld_a,
  input  logic [N*DW-1:0] ld_b,
  output logic [N*DW-1:0] a_feed,
  output logic [N*DW-1:0] b_feed,
  output logic            arr_clr,
  output logic            done
);

  import systolic_pkg::*;

  localparam int unsigned CW = $clog2(2 * N);
  localparam logic [CW-1:0] KLast = CW'(N - 1);
  localparam logic [CW-1:0] TLast = CW'(2 * N - 2);
  localparam logic [CW-1:0] DLast = CW'(N);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [N*DW-1:0] a_skew, b_skew;

  assign wr_en = (state_q == LOAD) && ld_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          if (cnt_q == KLast) begin
            state_d = FEED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FEED: begin
        if (cnt_q == TLast) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DLast) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Skew is evaluated on the next count so the feed register lines up with FEED/t.
  systolic_skew_gen #(
    .N  (N),
    .DW (DW),
    .CW (CW)
  ) u_skew (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_k   (cnt_q),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .t      (cnt_d),
    .a_skew (a_skew),
    .b_skew (b_skew)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      ld_ready <= 1'b0;
      arr_clr  <= 1'b0;
      done     <= 1'b0;
      a_feed   <= '0;
      b_feed   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d != IDLE);
      ld_ready <= (state_d == LOAD);
      arr_clr  <= (state_q == IDLE) && start;
      // done trails the DONE state by one cycle, landing in the following IDLE cycle.
      done     <= (state_q == DONE);
      a_feed   <= (state_d == FEED) ? a_skew : '0;
      b_feed   <= (state_d == FEED) ? b_skew : '0;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench: timeline reference model plus a behavioural MAC array on the feed outputs.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ld_valid = 1'b0;
  logic [W-1:0] ld_a = '0;
  logic [W-1:0] ld_b = '0;
  logic         busy, ld_ready, arr_clr, done;
  logic [W-1:0] a_feed, b_feed;

  systolic_ctrl #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .a_feed   (a_feed),
    .b_feed   (b_feed),
    .arr_clr  (arr_clr),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_beat = 0;
  int done_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cur_a [N][N];
  logic [7:0] cur_b [N][N];

  // Reference model: phase 0 idle, 1 load, 2 run; m_r counts cycles since the first feed cycle.
  int         m_phase = 0;
  int         m_beats = 0;
  int         m_r     = 0;
  bit         m_clr   = 1'b0;
  bit         m_done  = 1'b0;
  logic [7:0] m_a [N][N];
  logic [7:0] m_b [N][N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_beats <= 0;
      m_r     <= 0;
      m_clr   <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_clr  <= 1'b0;
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_beats <= 0;
          m_clr   <= 1'b1;
        end
      end else if (m_phase == 1) begin
        if (ld_valid) begin
          for (int i = 0; i < N; i++) begin
            m_a[i][m_beats] <= ld_a[i*DW +: DW];
            m_b[m_beats][i] <= ld_b[i*DW +: DW];
          end
          m_beats <= m_beats + 1;
          if (m_beats == N - 1) begin
            m_phase <= 2;
            m_r     <= 0;
          end
        end
      end else begin
        // 2N-1 feed cycles, N+1 drain cycles, one DONE cycle, then done in the idle cycle.
        if (m_r == 3 * N) begin
          m_phase <= 0;
          m_done  <= 1'b1;
        end else begin
          m_r <= m_r + 1;
        end
      end
    end
  end

  // Behavioural output-stationary array driven by the controller; not reset, only arr_clr clears.
  int         acc [N][N];
  logic [7:0] pa  [N][N];
  logic [7:0] pb  [N][N];

  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return a_feed[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return b_feed[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc[i][j] = 0;
        pa[i][j]  = '0;
        pb[i][j]  = '0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_clr) acc[i][j] <= 0;
        else if (a_in(i, j) != 0 && b_in(i, j) != 0)
          acc[i][j] <= acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
        pa[i][j] <= a_in(i, j);
        pb[i][j] <= b_in(i, j);
      end
    end
  end

  function automatic logic [W-1:0] exp_feed(bit is_b);
    logic [W-1:0] v = '0;
    if (m_phase == 2 && m_r <= 2 * N - 2) begin
      for (int l = 0; l < N; l++) begin
        int d = m_r - l;
        if (d >= 0 && d < N) v[l*DW +: DW] = is_b ? m_b[d][l] : m_a[l][d];
      end
    end
    return v;
  endfunction

  function automatic int exp_c(int i, int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(m_a[i][k]) * int'(m_b[k][j]);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("ld_ready", 64'(ld_ready), 64'(m_phase == 1));
    chk("arr_clr", 64'(arr_clr), 64'(m_clr));
    chk("done", 64'(done), 64'(m_done));
    chk("a_feed", 64'(a_feed), 64'(exp_feed(1'b0)));
    chk("b_feed", 64'(b_feed), 64'(exp_feed(1'b1)));
    if (m_done) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) chk("c_result", 64'(acc[i][j]), 64'(exp_c(i, j)));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_beats(input int mode);
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int k = 0;
    int p = 0;
    int guard = 0;
    while (k < N && guard < 100) begin
      bit v;
      bit acc_b;
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = pat[p % 7];
      else v = 1'($urandom_range(0, 1));
      ld_valid = v;
      if (v) begin
        for (int i = 0; i < N; i++) begin
          ld_a[i*DW +: DW] = cur_a[i][k];
          ld_b[i*DW +: DW] = cur_b[k][i];
        end
      end else begin
        ld_a = W'($urandom);
        ld_b = W'($urandom);
      end
      acc_b = v && ld_ready;
      if (acc_b && k == N - 1) last_beat = cyc;
      step();
      if (acc_b) k++;
      p++;
      guard++;
    end
    ld_valid = 1'b0;
    chk("beats_loaded", 64'(k), 64'(N));
  endtask

  task automatic wait_done(input bit noise);
    int g = 0;
    bit seen = 1'b0;
    while (!seen && g < 100) begin
      if (noise) begin
        start    = (g == 2 || g == 9);
        ld_valid = (g == 5);
      end
      step();
      g++;
      seen = done;
    end
    if (noise) begin
      start    = 1'b0;
      ld_valid = 1'b0;
    end
    done_cyc = cyc;
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        cur_a[i][j] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        cur_b[i][j] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
    end
  endtask

  initial begin
    int g;
    for (int i = 0; i < 3; i++) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_feeds", 64'({a_feed, b_feed}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Identity A times B[i][j] = 4i+j+1, gapped load, stray start/ld_valid while running.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cur_a[i][j] = (i == j) ? 8'd1 : 8'd0;
        cur_b[i][j] = 8'(4 * i + j + 1);
      end
    start_job();
    load_beats(1);
    chk("feed_t0_a", 64'(a_feed), 64'h0000_0001);
    chk("feed_t0_b", 64'(b_feed), 64'h0000_0001);
    step();
    chk("feed_t1_a", 64'(a_feed), 64'h0000_0000);
    chk("feed_t1_b", 64'(b_feed), 64'h0000_0205);
    wait_done(1'b1);
    chk("latency", 64'(done_cyc - last_beat), 64'd14);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("c_ident", 64'(acc[i][j]), 64'(4 * i + j + 1));
    for (int i = 0; i < 4; i++) step();

    // Back-to-back with start held: second arr_clr lands one cycle after the first done.
    fill_rand();
    start = 1'b1;
    step();
    load_beats(2);
    wait_done(1'b0);
    fill_rand();
    step();
    start = 1'b0;
    chk("b2b_clr", 64'(arr_clr), 64'd1);
    load_beats(2);
    wait_done(1'b0);
    for (int i = 0; i < 3; i++) step();

    // Reset during FEED t=3, then an all-2 job must not see stale partial sums.
    fill_rand();
    start_job();
    load_beats(0);
    g = 0;
    while (!(m_phase == 2 && m_r == 3) && g < 50) begin
      step();
      g++;
    end
    chk("reached_t3", 64'(m_r), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ctl", 64'({ld_ready, arr_clr, done}), 64'd0);
    chk("arst_feeds", 64'({a_feed, b_feed}), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cur_a[i][j] = 8'd2;
        cur_b[i][j] = 8'd2;
      end
    start_job();
    chk("rerun_clr", 64'(arr_clr), 64'd1);
    load_beats(2);
    wait_done(1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("c_all2", 64'(acc[i][j]), 64'd16);

    // Random jobs with random gaps and zero elements.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2; i++) step();
      fill_rand();
      start_job();
      load_beats(2);
      wait_done(1'b0);
    end
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
